// File: rtl/fx2_stream_writer.sv
// ---------------------------------------------------------------------------
// fx2_stream_writer
//
// Last stage of the I/Q DDC chain. 32-bit {Q[15:0], I[15:0]} FIR words are
// buffered in a small synchronous FIFO. Each word is written to the FX2LP
// slave FIFO as four bytes, least significant byte first:
// I[7:0], I[15:8], Q[7:0], Q[15:8]. The FX2 full flag stalls the byte
// stream. Words that arrive while the FIFO is full are dropped and counted.
//
// Optional build macro:
//   FX2_PKTEND_TIMEOUT_EN - when defined, PKTEND# is pulsed low for one
//   cycle after PKT_TIMEOUT idle cycles that follow at least one written
//   byte. This commits short packets so that slow streams reach the host.
//   When the macro is undefined, pktendn is tied high.
//
// Parameters:
//   DEPTH_LOG2   log2 of the FIFO depth in 32-bit words
//   PKT_TIMEOUT  idle clk cycles before PKTEND# is issued (must be >= 2)
//
// Ports (everything is on the rising edge of clk, the 48 MHz IFCLK):
//   clk           IFCLK
//   reset         synchronous, active-high
//   in_data       sample word {Q, I}
//   in_valid      one-cycle sample strobe
//   in_ready      FIFO not full; informational only, upstream never stalls
//   fd            FX2 FD data byte
//   slwrn         FX2 SLWR#, active-low write strobe
//   pktendn       FX2 PKTEND#, active-low
//   full_n        FX2 full flag, low = endpoint full
//   level         FIFO occupancy in words
//   overflow_cnt  number of dropped samples, saturating
//
// FSM states:
//   state   | meaning
//   IDLE    | no word in flight; load the head word when level != 0 and full_n
//   B0..B2  | byte k was last presented; byte k+1 is pending (slwrn=1 means stalled)
//   B3      | last byte of the word is on fd; return to IDLE after it is written
//   PEND    | PKTEND# low for one cycle (timeout build only)
// ---------------------------------------------------------------------------
module fx2_stream_writer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int PKT_TIMEOUT = 48000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            fd,
    output logic                  slwrn,
    output logic                  pktendn,
    input  logic                  full_n,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           overflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_B0   = 3'd1;
    localparam logic [2:0] ST_B1   = 3'd2;
    localparam logic [2:0] ST_B2   = 3'd3;
    localparam logic [2:0] ST_B3   = 3'd4;
`ifdef FX2_PKTEND_TIMEOUT_EN
    localparam logic [2:0] ST_PEND = 3'd5;
`endif

    logic [31:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    level_nxt;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [31:0]            head_word;

    logic [2:0]             state;
    logic [2:0]             next_state;
    logic [7:0]             next_byte;
    // Upper three bytes of the word in flight; byte 0 goes straight to fd.
    logic [23:0]            hold_q;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign full      = (level == LEVEL_FULL);
    assign push      = in_valid && !full;
    assign drop      = in_valid && full;
    assign pop       = (state == ST_IDLE) && (level != '0) && full_n;
    assign head_word = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage needs no reset: reset clears the pointers and level, which
    // discards whatever the array still holds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            in_ready     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_nxt;
            in_ready <= (level_nxt != LEVEL_FULL);
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Short-packet timeout
    // ------------------------------------------------------------------
`ifdef FX2_PKTEND_TIMEOUT_EN
    localparam int TMR_W = (PKT_TIMEOUT > 2) ? $clog2(PKT_TIMEOUT) : 1;
    // Reloaded on every written byte; the PKTEND decision is taken on the
    // idle edge that finds the counter at zero, which puts the pulse
    // PKT_TIMEOUT cycles after the last strobe.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PKT_TIMEOUT - 2);

    logic [TMR_W-1:0] idle_tmr;
    logic             wrote_since_pkt;
    logic             idle_tick;
    logic             timeout_hit;

    assign idle_tick   = (state == ST_IDLE) && (level == '0) && wrote_since_pkt;
    assign timeout_hit = idle_tick && (idle_tmr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_tmr        <= TMR_LOAD;
            wrote_since_pkt <= 1'b0;
        end else if (!slwrn) begin
            idle_tmr        <= TMR_LOAD;
            wrote_since_pkt <= 1'b1;
        end else if (timeout_hit) begin
            idle_tmr        <= TMR_LOAD;
            wrote_since_pkt <= 1'b0;
        end else if (idle_tick) begin
            idle_tmr <= idle_tmr - 1'b1;
        end
    end

    // PEND lasts exactly one cycle, so PKTEND# is simply the registered hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pktendn <= 1'b1;
        end else begin
            pktendn <= !timeout_hit;
        end
    end
`else
    // The timeout length only matters when the feature is built in.
    logic unused_timeout;
    assign unused_timeout = (PKT_TIMEOUT != 0);
    assign pktendn        = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Byte serialiser
    // ------------------------------------------------------------------
    always_comb begin
        next_byte  = hold_q[7:0];
        next_state = ST_B1;
        case (state)
            ST_B0: begin
                next_byte  = hold_q[7:0];
                next_state = ST_B1;
            end
            ST_B1: begin
                next_byte  = hold_q[15:8];
                next_state = ST_B2;
            end
            ST_B2: begin
                next_byte  = hold_q[23:16];
                next_state = ST_B3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            slwrn  <= 1'b1;
            fd     <= '0;
            hold_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    slwrn <= 1'b1;
                    if (pop) begin
                        hold_q <= head_word[31:8];
                        fd     <= head_word[7:0];
                        slwrn  <= 1'b0;
                        state  <= ST_B0;
                    end
`ifdef FX2_PKTEND_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= ST_PEND;
                    end
`endif
                end
                // Whether the current byte was just written or is still
                // stalled, full_n high presents the pending byte; full_n low
                // parks with fd unchanged so a byte is never repeated.
                ST_B0, ST_B1, ST_B2: begin
                    if (full_n) begin
                        fd    <= next_byte;
                        slwrn <= 1'b0;
                        state <= next_state;
                    end else begin
                        slwrn <= 1'b1;
                    end
                end
                ST_B3: begin
                    slwrn <= 1'b1;
                    state <= ST_IDLE;
                end
`ifdef FX2_PKTEND_TIMEOUT_EN
                ST_PEND: begin
                    slwrn <= 1'b1;
                    state <= ST_IDLE;
                end
`endif
                default: begin
                    slwrn <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_stream_writer.sv
// Bench for fx2_stream_writer: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// queue-based model of the FIFO and the byte stream.
module tb_fx2_stream_writer;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int TMO   = 50;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [31:0]   in_data  = '0;
    logic          in_valid = 1'b0;
    logic          full_n   = 1'b1;
    logic          in_ready;
    logic          slwrn;
    logic          pktendn;
    logic [7:0]    fd;
    logic [DL:0]   level;
    logic [15:0]   overflow_cnt;

    fx2_stream_writer #(
        .DEPTH_LOG2  (DL),
        .PKT_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fd           (fd),
        .slwrn        (slwrn),
        .pktendn      (pktendn),
        .full_n       (full_n),
        .level        (level),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO as a queue, the word in flight as (word, byte
    // index), plus the overflow and idle counters.
    // ------------------------------------------------------------------
    logic [31:0] mq[$];
    bit          m_on = 1'b0;
    bit          m_active;
    int          m_idx;
    logic [31:0] m_word;
    logic        m_slwrn;
    logic        m_pktendn;
    logic        m_in_ready;
    logic [7:0]  m_fd;
    int          m_ovf;
    bit          m_wrote;
    int          m_idle;

    always @(posedge clk) begin : model
        int sz;
        bit wr;
        bit in_pend;
        if (reset) begin
            mq.delete();
            m_active   = 1'b0;
            m_idx      = 0;
            m_slwrn    = 1'b1;
            m_pktendn  = 1'b1;
            m_fd       = 8'h00;
            m_ovf      = 0;
            m_in_ready = 1'b0;
            m_wrote    = 1'b0;
            m_idle     = 0;
            m_on       = 1'b1;
        end else if (m_on) begin
            sz      = mq.size();
            wr      = (m_slwrn == 1'b0);
            in_pend = (m_pktendn == 1'b0);
            if (wr) begin
                m_wrote = 1'b1;
                m_idle  = 0;
            end
            if (m_active) begin
                if (wr && m_idx == 3) begin
                    m_active = 1'b0;
                    m_slwrn  = 1'b1;
                end else if (full_n) begin
                    m_idx   = m_idx + 1;
                    m_fd    = m_word[8*m_idx +: 8];
                    m_slwrn = 1'b0;
                end else begin
                    m_slwrn = 1'b1;
                end
            end else if (in_pend) begin
                m_pktendn = 1'b1;
            end else if (sz != 0 && full_n) begin
                m_word   = mq.pop_front();
                m_active = 1'b1;
                m_idx    = 0;
                m_fd     = m_word[7:0];
                m_slwrn  = 1'b0;
            end else begin
                m_slwrn = 1'b1;
`ifdef FX2_PKTEND_TIMEOUT_EN
                if (sz == 0 && m_wrote) begin
                    if (m_idle == TMO - 2) begin
                        m_pktendn = 1'b0;
                        m_idle    = 0;
                        m_wrote   = 1'b0;
                    end else begin
                        m_idle = m_idle + 1;
                    end
                end
`endif
            end
            if (in_valid) begin
                if (sz < DEPTH) mq.push_back(in_data);
                else if (m_ovf < 65535) m_ovf = m_ovf + 1;
            end
            m_in_ready = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("slwrn", slwrn, m_slwrn);
            chk("fd", fd, m_fd);
            chk("pktendn", pktendn, m_pktendn);
            chk("level", level, mq.size());
            chk("in_ready", in_ready, m_in_ready);
            chk("overflow_cnt", overflow_cnt, m_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers and observers
    // ------------------------------------------------------------------
    int         tcyc = 0;
    logic [7:0] got[$];
    int         first_strobe;
    int         last_strobe;
    int         pend_cnt;
    int         pend_cyc;
    int         max_lvl;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            tcyc++;
            if (slwrn === 1'b0) begin
                got.push_back(fd);
                if (first_strobe < 0) first_strobe = tcyc;
                last_strobe = tcyc;
            end
            if (pktendn === 1'b0) begin
                pend_cnt++;
                pend_cyc = tcyc;
            end
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
    endtask

    task automatic clear_obs();
        got.delete();
        first_strobe = -1;
        last_strobe  = -1;
        pend_cnt     = 0;
        pend_cyc     = -1;
        max_lvl      = 0;
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        full_n   = 1'b1;
        tick(2);
        chk("rst_slwrn", slwrn, 1);
        chk("rst_pktendn", pktendn, 1);
        chk("rst_fd", fd, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        tick(1);
        chk("in_ready_after_rst", in_ready, 1);
    endtask

    task automatic push_word(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick(1);
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lvl1_cyc;
        int          bad;
        logic [31:0] base;
        logic [31:0] w;
        int          vp;
        int          fp;

        clear_obs();

        // Single word, free-running endpoint
        do_reset();
        clear_obs();
        push_word(32'hA1B2C3D4);
        chk("s1_level_one", level, 1);
        lvl1_cyc = tcyc;
        tick(8);
        chk("s1_strobes", got.size(), 4);
        chk("s1_byte0", got_at(0), 8'hD4);
        chk("s1_byte1", got_at(1), 8'hC3);
        chk("s1_byte2", got_at(2), 8'hB2);
        chk("s1_byte3", got_at(3), 8'hA1);
        chk("s1_first_strobe", first_strobe, lvl1_cyc + 1);
        chk("s1_level_zero", level, 0);

        // Stall from B1 for ten cycles
        do_reset();
        clear_obs();
        push_word(32'hA1B2C3D4);
        tick(2);
        chk("s2_b1_fd", fd, 8'hC3);
        chk("s2_b1_slwrn", slwrn, 0);
        full_n = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (slwrn !== 1'b1 || fd !== 8'hC3) bad++;
        end
        chk("s2_stall_hold", bad, 0);
        full_n = 1'b1;
        tick(6);
        chk("s2_strobes", got.size(), 4);
        chk("s2_byte0", got_at(0), 8'hD4);
        chk("s2_byte1", got_at(1), 8'hC3);
        chk("s2_byte2", got_at(2), 8'hB2);
        chk("s2_byte3", got_at(3), 8'hA1);

        // Overflow with the endpoint full, then drain in order
        do_reset();
        clear_obs();
        full_n = 1'b0;
        base   = $urandom;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            tick(1);
        end
        in_valid = 1'b0;
        tick(1);
        chk("s3_level_full", level, 16);
        chk("s3_in_ready", in_ready, 0);
        chk("s3_overflow", overflow_cnt, 4);
        got.delete();
        full_n = 1'b1;
        tick(16 * 5 + 10);
        chk("s3_bytes", got.size(), 64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            w = (base + 32'(i / 4)) >> (8 * (i % 4));
            if (got_at(i) !== w[7:0]) bad++;
        end
        chk("s3_order", bad, 0);
        chk("s3_drained", level, 0);

        // One word every five cycles
        do_reset();
        clear_obs();
        for (int i = 0; i < 100; i++) begin
            push_word($urandom);
            tick(4);
        end
        tick(10);
        chk("s4_max_level", max_lvl, 1);
        chk("s4_overflow", overflow_cnt, 0);
        chk("s4_strobes", got.size(), 400);

        // Idle timeout
        do_reset();
        clear_obs();
        push_word(32'h0BADCAFE);
        tick(60);
`ifdef FX2_PKTEND_TIMEOUT_EN
        chk("s5_pulses", pend_cnt, 1);
        chk("s5_delay", pend_cyc - last_strobe, 50);
        tick(200);
        chk("s5_no_repeat", pend_cnt, 1);
`else
        tick(200);
        chk("s5_no_pktend", pend_cnt, 0);
`endif

        // Reset while the first word is in B2
        do_reset();
        clear_obs();
        full_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick(1);
        end
        in_valid = 1'b0;
        full_n   = 1'b1;
        got.delete();
        for (int i = 0; i < 20 && got.size() < 3; i++) tick(1);
        chk("s6_reached_b2", got.size(), 3);
        chk("s6_overflow_before", overflow_cnt, 4);
        reset = 1'b1;
        tick(1);
        chk("s6_rst_slwrn", slwrn, 1);
        chk("s6_rst_fd", fd, 0);
        chk("s6_rst_level", level, 0);
        chk("s6_rst_overflow", overflow_cnt, 0);
        reset = 1'b0;
        tick(1);
        clear_obs();
        push_word(32'hCAFEF00D);
        tick(8);
        chk("s6_strobes", got.size(), 4);
        chk("s6_byte0", got_at(0), 8'h0D);
        chk("s6_byte1", got_at(1), 8'hF0);
        chk("s6_byte2", got_at(2), 8'hFE);
        chk("s6_byte3", got_at(3), 8'hCA);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            case (i / 1000)
                0:       begin vp = 20; fp = 90;  end
                1:       begin vp = 60; fp = 50;  end
                2:       begin vp = 2;  fp = 100; end
                default: begin vp = 40; fp = 70;  end
            endcase
            in_valid = ($urandom_range(0, 99) < vp);
            in_data  = $urandom;
            full_n   = ($urandom_range(0, 99) < fp);
            reset    = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        full_n   = 1'b1;
        tick(300);
        chk("rand_drained", level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
